// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/next-PC fetch stage with imem req/ack and decode valid/ready handshakes.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_sel,
`ifdef FETCH_PERF_CNT_EN
  input  logic [25:0] jump_target,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`else
  input  logic [25:0] jump_target
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic accept;
  assign accept = inst_valid & inst_ready;
  assign pc_plus4 = pc + 32'd4;
  assign imem_addr = fetch_pc;
  assign fetch_pc_nx = jump_sel     ? {pc_plus4[31:28], jump_target, 2'b00} :
                       branch_taken ? pc_plus4 + (branch_offset << 2) : pc_plus4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? REQ :
               state == REQ  ? (imem_ack ? HOLD : REQ) :
               state == HOLD ? (inst_ready ? REQ : HOLD) : IDLE;
  always_comb begin
    imem_req = state == REQ;
    inst_valid = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc <= RESET_PC & ~32'd3;
      instruction <= '0;
      pc <= '0;
    end else begin
      if (imem_req && imem_ack) begin
        instruction <= imem_rdata;
        pc <= fetch_pc;
      end
      if (accept) fetch_pc <= fetch_pc_nx;
    end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) fetch_cnt <= fetch_cnt + 32'd1;
      if (imem_req && !imem_ack) stall_cnt <= stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized self-checking bench for instr_fetch_unit against an address-level model.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  logic clk = 0, rst_n = 0;
  logic imem_req, imem_ack = 0, inst_valid, inst_ready = 0;
  logic branch_taken = 0, jump_sel = 0;
  logic [31:0] imem_addr, imem_rdata = 0, instruction, pc, pc_plus4, branch_offset = 0;
  logic [25:0] jump_target = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif
  int n_cmp = 0, n_fail = 0;
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] exp_fcnt = 0, exp_scnt = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4),
    .branch_taken(branch_taken), .branch_offset(branch_offset), .jump_sel(jump_sel),
`ifdef FETCH_PERF_CNT_EN
    .jump_target(jump_target), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`else
    .jump_target(jump_target)
`endif
  );

  always #5 clk = ~clk;

  // One full fetch: request (optionally stalled), hold (optionally unready), accept with given redirect.
  task automatic fetch_txn(input int ack_dly, input int rdy_dly, input logic j, input logic b,
                           input logic [31:0] off, input logic [25:0] tgt, input logic [31:0] word);
    logic [31:0] p4, nxt;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== exp_addr || inst_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL req_start: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", imem_req, imem_addr, inst_valid, exp_addr);
    end
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 0; imem_rdata = $urandom;
      @(posedge clk); #1;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr || inst_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_stall: req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", imem_req, imem_addr, inst_valid, exp_addr);
      end
    end
    imem_ack = 1; imem_rdata = word;
    @(posedge clk); #1;
    imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
    n_cmp++;
    if (inst_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== word || pc !== exp_addr || pc_plus4 !== exp_addr + 32'd4) begin
      n_fail++;
      $display("FAIL present: valid=%b req=%b instr=%h pc=%h pc4=%h expected 1 0 %h %h %h", inst_valid, imem_req, instruction, pc, pc_plus4, word, exp_addr, exp_addr + 32'd4);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      inst_ready = 0; jump_sel = 1'($urandom); branch_taken = 1'($urandom);
      branch_offset = $urandom; jump_target = 26'($urandom);
      imem_ack = 1'($urandom); imem_rdata = $urandom;
      @(posedge clk); #1;
      n_cmp++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b0 || instruction !== word || pc !== exp_addr || imem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL hold: valid=%b req=%b instr=%h pc=%h addr=%h expected 1 0 %h %h %h", inst_valid, imem_req, instruction, pc, imem_addr, word, exp_addr, exp_addr);
      end
    end
    p4 = exp_addr + 32'd4;
    nxt = j ? {p4[31:28], tgt, 2'b00} : b ? p4 + off * 32'd4 : p4;
    inst_ready = 1; jump_sel = j; branch_taken = b; branch_offset = off; jump_target = tgt;
    @(posedge clk); #1;
    inst_ready = 1'($urandom); imem_ack = 0;
    jump_sel = 1'($urandom); branch_taken = 1'($urandom); branch_offset = $urandom;
    exp_fcnt++; exp_scnt += 32'(ack_dly);
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== nxt) begin
      n_fail++;
      $display("FAIL next_addr: valid=%b req=%b addr=%h expected 0 1 %h", inst_valid, imem_req, imem_addr, nxt);
    end
    exp_addr = nxt;
`ifdef FETCH_PERF_CNT_EN
    n_cmp++;
    if (fetch_cnt !== exp_fcnt || stall_cnt !== exp_scnt) begin
      n_fail++;
      $display("FAIL perf_cnt: fetch=%0d stall=%0d expected %0d %0d", fetch_cnt, stall_cnt, exp_fcnt, exp_scnt);
    end
`endif
  endtask

  task automatic apply_reset();
    rst_n = 0; imem_ack = 0; inst_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    exp_addr = RST_PC; exp_fcnt = 0; exp_scnt = 0;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || instruction !== 32'h0 || pc !== 32'h0 || pc_plus4 !== 32'h4 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_vals: req=%b valid=%b instr=%h pc=%h pc4=%h addr=%h expected 0 0 0 0 4 %h", imem_req, inst_valid, instruction, pc, pc_plus4, imem_addr, RST_PC);
    end
    rst_n = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b req=%b expected 0 1", inst_valid, imem_req);
    end
  endtask

  task automatic test_sequential();
    exp_addr = RST_PC; exp_fcnt = 0; exp_scnt = 0;
    fetch_txn(0, 0, 0, 0, 32'h0, 26'h0, 32'h8C08_0004);
    n_cmp++;
    if (imem_addr !== 32'h0040_0004) begin
      n_fail++;
      $display("FAIL seq_addr: addr=%h expected 00400004", imem_addr);
    end
  endtask

  task automatic test_branch();
    fetch_txn(0, 0, 1, 0, 32'h0, 26'h010_0004, $urandom);
    fetch_txn(0, 1, 0, 1, 32'hFFFF_FFFC, 26'h0, $urandom);
    n_cmp++;
    if (imem_addr !== 32'h0040_0004) begin
      n_fail++;
      $display("FAIL branch_back: addr=%h expected 00400004", imem_addr);
    end
  endtask

  task automatic test_jump_priority();
    apply_reset();
    fetch_txn(0, 0, 1, 1, 32'h0000_0100, 26'h010_0008, $urandom);
    n_cmp++;
    if (imem_addr !== 32'h0040_0020) begin
      n_fail++;
      $display("FAIL jump_prio: addr=%h expected 00400020", imem_addr);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    fetch_txn(3, 4, 0, 0, 32'h0, 26'h0, $urandom);
    fetch_txn(2, 0, 0, 0, 32'h0, 26'h0, $urandom);
  endtask

  task automatic test_wrap_and_midreset();
    logic [31:0] off;
    off = (32'hFFFF_FFFC - exp_addr - 32'd4) >> 2;
    fetch_txn(1, 0, 0, 1, off, 26'h0, $urandom);
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL reach_top: addr=%h expected fffffffc", imem_addr);
    end
    fetch_txn(0, 0, 0, 0, 32'h0, 26'h0, $urandom);
    n_cmp++;
    if (imem_addr !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap: addr=%h expected 00000000", imem_addr);
    end
    imem_ack = 0;
    @(posedge clk); #1;
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; rst_n = 0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL midreset: req=%b valid=%b addr=%h expected 0 0 %h", imem_req, inst_valid, imem_addr, RST_PC);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (inst_valid !== 1'b0 || instruction !== 32'h0 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL ack_discard: valid=%b instr=%h pc=%h expected 0 0 0", inst_valid, instruction, pc);
    end
    imem_ack = 0; rst_n = 1;
    exp_addr = RST_PC; exp_fcnt = 0; exp_scnt = 0;
    @(posedge clk); #1;
    fetch_txn(0, 0, 0, 0, 32'h0, 26'h0, $urandom);
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++)
      fetch_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                1'($urandom), 32'($urandom_range(0, 64)) - 32'd32, 26'($urandom), $urandom);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump_priority();
    test_stall();
    test_wrap_and_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
